// File: rtl/dram_bus_retimer_pkg.sv
// Shared types and default widths for the DRAM pad retimer.
package dram_bus_pkg;

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    TURN_ON  = 2'd1,
    DRIVE    = 2'd2,
    PARK     = 2'd3
  } bus_state_t;

  localparam int DRAM_ADDR_W = 11;
  localparam int DRAM_DATA_W = 8;

endpackage

// File: rtl/dram_bus_retimer_sync.sv
// Multi-flop synchroniser for a single asynchronous level signal.
module bit_synchronizer #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], d};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) sync_q <= {STAGES{RESET_VAL}};
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/dram_bus_retimer.sv
// Registered DRAM pad interface with a bus-ownership FSM that parks the
// strobes high around every handover before enabling or releasing the pads.
module dram_bus_retimer
  import dram_bus_pkg::*;
#(
  parameter int ADDR_W      = DRAM_ADDR_W,
  parameter int DATA_W      = DRAM_DATA_W,
  parameter int RAS_CNT     = 2,
  parameter int CAS_CNT     = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TURN_CYCLES = 1,
  parameter int PARK_CYCLES = 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              core_bus_en,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_data_out,
  input  logic              core_data_out_en,
  input  logic              core_n_nren,
  input  logic [RAS_CNT-1:0] core_n_ras,
  input  logic [CAS_CNT-1:0] core_n_cas,
  input  logic              core_n_we,
  output logic [DATA_W-1:0] core_data_in,
  output logic              core_n_wait,
  output logic [ADDR_W-1:0] pad_addr,
  output logic [DATA_W-1:0] pad_data_out,
  input  logic [DATA_W-1:0] pad_data_in,
  output logic              pad_n_nren,
  output logic              pad_n_we,
  output logic [RAS_CNT-1:0] pad_n_ras,
  output logic [CAS_CNT-1:0] pad_n_cas,
  output logic              pad_ctrl_oe,
  output logic              pad_data_oe,
  input  logic              pad_n_wait,
  output logic              bus_released
);

  localparam int CNT_MAX   = (TURN_CYCLES > PARK_CYCLES) ? TURN_CYCLES : PARK_CYCLES;
  localparam int CNT_W     = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam int TURN_LAST = (TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0;
  localparam int PARK_LAST = (PARK_CYCLES > 0) ? PARK_CYCLES - 1 : 0;

  bus_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_out_q, data_out_d;
  logic [DATA_W-1:0]  data_in_q, data_in_d;
  logic               nren_q, nren_d;
  logic               we_q, we_d;
  logic [RAS_CNT-1:0] ras_q, ras_d;
  logic [CAS_CNT-1:0] cas_q, cas_d;
  logic               ctrl_oe_q, ctrl_oe_d;
  logic               data_oe_q, data_oe_d;
  logic               released_q, released_d;
  logic               pass;

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + 1'b1;
    // Bus-enable changes win over counter expiry in every state.
    case (state_q)
      RELEASED: if (core_bus_en) state_d = (TURN_CYCLES == 0) ? DRIVE : TURN_ON;
      TURN_ON: begin
        if (!core_bus_en)                    state_d = PARK;
        else if (cnt_q >= CNT_W'(TURN_LAST)) state_d = DRIVE;
      end
      DRIVE:   if (!core_bus_en) state_d = PARK;
      PARK: begin
        if (core_bus_en)                     state_d = DRIVE;
        else if (cnt_q >= CNT_W'(PARK_LAST)) state_d = RELEASED;
      end
      default: state_d = RELEASED;
    endcase
    if (state_d != state_q) cnt_d = '0;

    // Strobes only follow the core while it still owns the bus this cycle.
    pass       = (state_q == DRIVE) && core_bus_en;
    nren_d     = pass ? core_n_nren : 1'b1;
    we_d       = pass ? core_n_we   : 1'b1;
    ras_d      = pass ? core_n_ras  : '1;
    cas_d      = pass ? core_n_cas  : '1;
    data_oe_d  = pass && core_data_out_en;
    addr_d     = (state_q == TURN_ON || state_q == DRIVE) ? core_addr : addr_q;
    data_out_d = (state_q == DRIVE) ? core_data_out : data_out_q;
    data_in_d  = pad_data_in;
    ctrl_oe_d  = (state_d != RELEASED);
    released_d = (state_d == RELEASED);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= RELEASED;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_out_q <= '0;
      data_in_q  <= '0;
      nren_q     <= 1'b1;
      we_q       <= 1'b1;
      ras_q      <= '1;
      cas_q      <= '1;
      ctrl_oe_q  <= 1'b0;
      data_oe_q  <= 1'b0;
      released_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_out_q <= data_out_d;
      data_in_q  <= data_in_d;
      nren_q     <= nren_d;
      we_q       <= we_d;
      ras_q      <= ras_d;
      cas_q      <= cas_d;
      ctrl_oe_q  <= ctrl_oe_d;
      data_oe_q  <= data_oe_d;
      released_q <= released_d;
    end
  end

  bit_synchronizer #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b1)
  ) u_wait_sync (
    .clk  (clk),
    .n_rst(n_rst),
    .d    (pad_n_wait),
    .q    (core_n_wait)
  );

  assign core_data_in = data_in_q;
  assign pad_addr     = addr_q;
  assign pad_data_out = data_out_q;
  assign pad_n_nren   = nren_q;
  assign pad_n_we     = we_q;
  assign pad_n_ras    = ras_q;
  assign pad_n_cas    = cas_q;
  assign pad_ctrl_oe  = ctrl_oe_q;
  assign pad_data_oe  = data_oe_q;
  assign bus_released = released_q;

endmodule

// File: tb/tb_dram_bus_retimer.sv
// Directed bench for dram_bus_retimer: a default instance plus a long-park instance.
module tb_dram_bus_retimer;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        core_bus_en;
  logic [10:0] core_addr;
  logic [7:0]  core_data_out;
  logic        core_data_out_en;
  logic        core_n_nren;
  logic [1:0]  core_n_ras;
  logic [1:0]  core_n_cas;
  logic        core_n_we;
  logic [7:0]  pad_data_in;
  logic        pad_n_wait;

  logic [7:0]  core_data_in;
  logic        core_n_wait;
  logic [10:0] pad_addr;
  logic [7:0]  pad_data_out;
  logic        pad_n_nren, pad_n_we;
  logic [1:0]  pad_n_ras, pad_n_cas;
  logic        pad_ctrl_oe, pad_data_oe, bus_released;

  logic [7:0]  b_core_data_in;
  logic        b_core_n_wait;
  logic [10:0] b_pad_addr;
  logic [7:0]  b_pad_data_out;
  logic        b_pad_n_nren, b_pad_n_we;
  logic [1:0]  b_pad_n_ras, b_pad_n_cas;
  logic        b_pad_ctrl_oe, b_pad_data_oe, b_bus_released;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dram_bus_retimer u_dut (
    .clk(clk), .n_rst(n_rst), .core_bus_en(core_bus_en), .core_addr(core_addr),
    .core_data_out(core_data_out), .core_data_out_en(core_data_out_en),
    .core_n_nren(core_n_nren), .core_n_ras(core_n_ras), .core_n_cas(core_n_cas),
    .core_n_we(core_n_we), .core_data_in(core_data_in), .core_n_wait(core_n_wait),
    .pad_addr(pad_addr), .pad_data_out(pad_data_out), .pad_data_in(pad_data_in),
    .pad_n_nren(pad_n_nren), .pad_n_we(pad_n_we), .pad_n_ras(pad_n_ras),
    .pad_n_cas(pad_n_cas), .pad_ctrl_oe(pad_ctrl_oe), .pad_data_oe(pad_data_oe),
    .pad_n_wait(pad_n_wait), .bus_released(bus_released)
  );

  dram_bus_retimer #(.PARK_CYCLES(3)) u_long_park (
    .clk(clk), .n_rst(n_rst), .core_bus_en(core_bus_en), .core_addr(core_addr),
    .core_data_out(core_data_out), .core_data_out_en(core_data_out_en),
    .core_n_nren(core_n_nren), .core_n_ras(core_n_ras), .core_n_cas(core_n_cas),
    .core_n_we(core_n_we), .core_data_in(b_core_data_in), .core_n_wait(b_core_n_wait),
    .pad_addr(b_pad_addr), .pad_data_out(b_pad_data_out), .pad_data_in(pad_data_in),
    .pad_n_nren(b_pad_n_nren), .pad_n_we(b_pad_n_we), .pad_n_ras(b_pad_n_ras),
    .pad_n_cas(b_pad_n_cas), .pad_ctrl_oe(b_pad_ctrl_oe), .pad_data_oe(b_pad_data_oe),
    .pad_n_wait(pad_n_wait), .bus_released(b_bus_released)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    core_bus_en = 1'b1; core_addr = 11'h123; core_data_out = 8'h00;
    core_data_out_en = 1'b0; core_n_nren = 1'b0; core_n_ras = 2'b00;
    core_n_cas = 2'b00; core_n_we = 1'b0; pad_data_in = 8'h00; pad_n_wait = 1'b1;
    tick(); tick();
    checks++; if (pad_ctrl_oe !== 1'b0 || pad_data_oe !== 1'b0) begin errors++;
      $display("FAIL reset_oe: got ctrl=%b data=%b want 0 0", pad_ctrl_oe, pad_data_oe); end
    checks++; if ({pad_n_ras, pad_n_cas, pad_n_nren, pad_n_we} !== 6'b111111) begin errors++;
      $display("FAIL reset_strobes: got %b want 111111", {pad_n_ras, pad_n_cas, pad_n_nren, pad_n_we}); end
    checks++; if (core_n_wait !== 1'b1 || bus_released !== 1'b1) begin errors++;
      $display("FAIL reset_wait_rel: got n_wait=%b rel=%b want 1 1", core_n_wait, bus_released); end
    checks++; if (pad_addr !== 11'h000 || pad_data_out !== 8'h00 || core_data_in !== 8'h00) begin errors++;
      $display("FAIL reset_data: got addr=%h dout=%h din=%h want 0", pad_addr, pad_data_out, core_data_in); end
    n_rst = 1'b1;
    tick(); // edge 1: RELEASED -> TURN_ON
    checks++; if (pad_ctrl_oe !== 1'b1 || bus_released !== 1'b0 || pad_n_ras !== 2'b11) begin errors++;
      $display("FAIL turn_on_entry: got ctrl=%b rel=%b ras=%b want 1 0 11", pad_ctrl_oe, bus_released, pad_n_ras); end
    tick(); // edge 2: TURN_ON -> DRIVE, strobes still high, address tracks
    checks++; if (pad_n_ras !== 2'b11 || pad_addr !== 11'h123) begin errors++;
      $display("FAIL turn_on_hold: got ras=%b addr=%h want 11 123", pad_n_ras, pad_addr); end
    tick(); // edge 3: first pass-through
    checks++; if (pad_n_ras !== 2'b00 || pad_n_cas !== 2'b00 || pad_n_we !== 1'b0) begin errors++;
      $display("FAIL first_pass: got ras=%b cas=%b we=%b want 00 00 0", pad_n_ras, pad_n_cas, pad_n_we); end
  endtask

  task automatic test_pass_through();
    core_n_cas = 2'b10; core_addr = 11'h5A5; core_data_out = 8'h3C;
    core_data_out_en = 1'b1; core_n_we = 1'b0; core_n_ras = 2'b01;
    checks++; if (pad_addr === 11'h5A5) begin errors++;
      $display("FAIL pass_early: got addr=%h before edge want 123", pad_addr); end
    tick();
    checks++; if (pad_n_cas !== 2'b10 || pad_addr !== 11'h5A5 || pad_n_ras !== 2'b01) begin errors++;
      $display("FAIL pass_vec1: got cas=%b addr=%h ras=%b want 10 5a5 01", pad_n_cas, pad_addr, pad_n_ras); end
    checks++; if (pad_data_out !== 8'h3C || pad_data_oe !== 1'b1) begin errors++;
      $display("FAIL pass_data1: got dout=%h doe=%b want 3c 1", pad_data_out, pad_data_oe); end
    core_n_cas = 2'b01; core_addr = 11'h7FF; core_data_out = 8'hC3;
    core_data_out_en = 1'b0; core_n_we = 1'b1; core_n_nren = 1'b1;
    tick();
    checks++; if (pad_n_cas !== 2'b01 || pad_addr !== 11'h7FF || pad_data_oe !== 1'b0 || pad_n_we !== 1'b1) begin errors++;
      $display("FAIL pass_vec2: got cas=%b addr=%h doe=%b we=%b want 01 7ff 0 1", pad_n_cas, pad_addr, pad_data_oe, pad_n_we); end
  endtask

  task automatic test_park();
    core_n_ras = 2'b00; core_n_cas = 2'b00; core_data_out_en = 1'b1;
    tick();
    checks++; if (pad_n_ras !== 2'b00 || pad_data_oe !== 1'b1) begin errors++;
      $display("FAIL park_pre: got ras=%b doe=%b want 00 1", pad_n_ras, pad_data_oe); end
    core_bus_en = 1'b0;
    tick();
    checks++; if (pad_n_ras !== 2'b11 || pad_n_cas !== 2'b11 || pad_data_oe !== 1'b0 || pad_ctrl_oe !== 1'b1) begin errors++;
      $display("FAIL park_entry: got ras=%b cas=%b doe=%b ctrl=%b want 11 11 0 1", pad_n_ras, pad_n_cas, pad_data_oe, pad_ctrl_oe); end
    tick();
    checks++; if (pad_ctrl_oe !== 1'b0 || bus_released !== 1'b1) begin errors++;
      $display("FAIL park_release: got ctrl=%b rel=%b want 0 1", pad_ctrl_oe, bus_released); end
    checks++; if (b_pad_ctrl_oe !== 1'b1 || b_bus_released !== 1'b0) begin errors++;
      $display("FAIL long_park_hold: got ctrl=%b rel=%b want 1 0", b_pad_ctrl_oe, b_bus_released); end
    tick(); tick();
    checks++; if (b_pad_ctrl_oe !== 1'b0 || b_bus_released !== 1'b1) begin errors++;
      $display("FAIL long_park_release: got ctrl=%b rel=%b want 0 1", b_pad_ctrl_oe, b_bus_released); end
  endtask

  task automatic test_park_abort();
    core_bus_en = 1'b1;
    tick(); tick(); tick();
    checks++; if (b_pad_n_ras !== 2'b00 || pad_n_ras !== 2'b00) begin errors++;
      $display("FAIL abort_drive: got b_ras=%b ras=%b want 00 00", b_pad_n_ras, pad_n_ras); end
    core_bus_en = 1'b0;
    tick();
    checks++; if (b_pad_ctrl_oe !== 1'b1 || b_pad_n_ras !== 2'b11) begin errors++;
      $display("FAIL abort_park: got ctrl=%b ras=%b want 1 11", b_pad_ctrl_oe, b_pad_n_ras); end
    core_bus_en = 1'b1;
    tick();
    checks++; if (b_pad_ctrl_oe !== 1'b1 || b_pad_n_ras !== 2'b11 || pad_ctrl_oe !== 1'b1) begin errors++;
      $display("FAIL abort_redrive: got b_ctrl=%b b_ras=%b ctrl=%b want 1 11 1", b_pad_ctrl_oe, b_pad_n_ras, pad_ctrl_oe); end
    tick();
    checks++; if (b_pad_ctrl_oe !== 1'b1 || b_pad_n_ras !== 2'b00 || pad_n_ras !== 2'b00 || bus_released !== 1'b0) begin errors++;
      $display("FAIL abort_pass: got b_ctrl=%b b_ras=%b ras=%b rel=%b want 1 00 00 0", b_pad_ctrl_oe, b_pad_n_ras, pad_n_ras, bus_released); end
  endtask

  task automatic test_n_wait();
    logic exp;
    pad_n_wait = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 4) pad_n_wait = 1'b1;
      exp = (k >= 2 && k <= 5) ? 1'b0 : 1'b1;
      checks++; if (core_n_wait !== exp) begin errors++;
        $display("FAIL n_wait_edge%0d: got %b want %b", k, core_n_wait, exp); end
    end
  endtask

  task automatic test_read_data();
    pad_data_in = 8'hA5;
    checks++; if (core_data_in === 8'hA5) begin errors++;
      $display("FAIL rdata_early: got %h before edge", core_data_in); end
    tick();
    checks++; if (core_data_in !== 8'hA5) begin errors++;
      $display("FAIL rdata_1: got %h want a5", core_data_in); end
    pad_data_in = 8'h5A;
    tick();
    checks++; if (core_data_in !== 8'h5A) begin errors++;
      $display("FAIL rdata_2: got %h want 5a", core_data_in); end
  endtask

  task automatic test_async_reset();
    core_data_out_en = 1'b1; core_n_ras = 2'b00;
    tick();
    checks++; if (pad_data_oe !== 1'b1 || pad_ctrl_oe !== 1'b1) begin errors++;
      $display("FAIL areset_pre: got doe=%b ctrl=%b want 1 1", pad_data_oe, pad_ctrl_oe); end
    #2 n_rst = 1'b0;
    #1;
    checks++; if (pad_ctrl_oe !== 1'b0 || pad_data_oe !== 1'b0 || pad_n_ras !== 2'b11 || bus_released !== 1'b1) begin errors++;
      $display("FAIL areset_mid: got ctrl=%b doe=%b ras=%b rel=%b want 0 0 11 1", pad_ctrl_oe, pad_data_oe, pad_n_ras, bus_released); end
    tick();
    n_rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_park();
    test_park_abort();
    test_n_wait();
    test_read_data();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
